// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

    localparam int PC_W_DEF     = 13;
    localparam int INSTR_W_DEF  = 32;
    localparam int RESET_PC_DEF = 0;

    // Program counter type, also used for the execute stage's jump target.
    typedef logic [PC_W_DEF-1:0] pc_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        STREAM = 2'd1,
        HELD   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register that parks an instruction returning from memory
// while decode is stalled.
module fetch_skid #(
    parameter int PC_W    = 13,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    // Load takes priority; the controller never asserts both together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues reads to a synchronous instruction memory and
// hands instructions to decode through the IF/ID register. Redirects from
// execute cost one bubble; a one-entry skid absorbs the read that is already
// in flight when decode stalls.
//
// state  | meaning
// -------+-----------------------------------------------
// EMPTY  | no read in flight, skid empty
// STREAM | one read in flight, its data arrives this cycle
// HELD   | skid holds an instruction decode has not taken
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    jaddr,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               instr_valid
);

    logic [PC_W-1:0]    pc_q;
    logic               infl;
    logic [PC_W-1:0]    infl_pc;
    logic               skid_v;
    logic [INSTR_W-1:0] skid_instr;
    logic [PC_W-1:0]    skid_pc;

    logic               skid_load;
    logic               skid_clear;
    logic               out_load;
    logic               out_from_skid;
    logic               valid_d;
    fetch_state_t       state;

    // A redirect always issues, even under stall, so the target read starts at once.
    assign imem_en   = branch_taken | ~stall;
    assign imem_addr = branch_taken ? jaddr : pc_q;

    // Current state follows directly from the in-flight and skid flags.
    assign state = skid_v ? HELD : (infl ? STREAM : EMPTY);

    // Issue tracking: at most one read outstanding, pc wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            infl    <= 1'b0;
            infl_pc <= '0;
        end else if (imem_en) begin
            pc_q    <= imem_addr + PC_W'(1);
            infl    <= 1'b1;
            infl_pc <= imem_addr;
        end else begin
            infl    <= 1'b0;
        end
    end

    // Next-state control: redirect beats stall, stall parks arriving data.
    always_comb begin
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        out_load      = 1'b0;
        out_from_skid = 1'b0;
        valid_d       = instr_valid;
        if (branch_taken) begin
            skid_clear = 1'b1;
            valid_d    = 1'b0;
        end else if (!stall) begin
            case (state)
                HELD: begin
                    out_load      = 1'b1;
                    out_from_skid = 1'b1;
                    skid_clear    = 1'b1;
                    valid_d       = 1'b1;
                end
                STREAM: begin
                    out_load = 1'b1;
                    valid_d  = 1'b1;
                end
                default: valid_d = 1'b0;
            endcase
        end else if (state == STREAM) begin
            skid_load = 1'b1;
        end
    end

    // IF/ID output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= valid_d;
            if (out_load) begin
                instr_out <= out_from_skid ? skid_instr : imem_rdata;
                pc_out    <= out_from_skid ? skid_pc : infl_pc;
            end
        end
    end

    fetch_skid #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_instr (imem_rdata),
        .d_pc    (infl_pc),
        .valid   (skid_v),
        .instr   (skid_instr),
        .pc      (skid_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/branch
// traffic, checked against a queue-based model of program-order delivery.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [12:0] jaddr;
    logic        imem_en;
    logic [12:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [12:0] pc_out;
    logic        instr_valid;

    int total = 0;
    int bad   = 0;

    // Reference model: addresses issued but not yet delivered, next sequential pc.
    int q[$];
    int next_pc;
    bit exp_valid;
    int exp_pc;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jaddr        (jaddr),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [12:0] a);
        return {a ^ 13'h1555, 6'h2A, a};
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= instr_of(imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_pc   = 0;
        exp_valid = 1'b0;
        exp_pc    = 0;
    endtask

    task automatic step(input logic b, input logic [12:0] j, input logic s);
        branch_taken = b;
        jaddr        = j;
        stall        = s;
        #1;
        chk("imem_en", {31'd0, imem_en}, {31'd0, b | ~s});
        if (b || !s) chk("imem_addr", {19'd0, imem_addr}, b ? {19'd0, j} : next_pc);
        @(posedge clk);
        if (b) begin
            q.delete();
            q.push_back(int'(j));
            next_pc   = (int'(j) + 1) % 8192;
            exp_valid = 1'b0;
        end else if (!s) begin
            if (q.size() > 0) begin
                exp_pc    = q.pop_front();
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
            q.push_back(next_pc);
            next_pc = (next_pc + 1) % 8192;
        end
        #1;
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("pc_out", {19'd0, pc_out}, exp_pc);
            chk("instr_out", instr_out, instr_of(exp_pc[12:0]));
        end
    endtask

    initial begin
        rst          = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        jaddr        = '0;
        imem_rdata   = '0;
        model_reset();

        // Reset values.
        #12;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc_out", {19'd0, pc_out}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_imem_addr", {19'd0, imem_addr}, 32'd0);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd1);
        stall = 1'b1;
        #1;
        chk("rst_imem_en_stall", {31'd0, imem_en}, 32'd0);
        stall = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Boot: pc_out 0..5 on cycles 2..7.
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0);
        chk("boot_pc5", {19'd0, pc_out}, 32'd5);

        // Three-cycle stall while streaming, then release.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b1);
            chk("stall_hold_pc", {19'd0, pc_out}, 32'd5);
        end
        step(1'b0, '0, 1'b0);
        chk("release_pc6", {19'd0, pc_out}, 32'd6);
        step(1'b0, '0, 1'b0);
        chk("release_pc7", {19'd0, pc_out}, 32'd7);

        // Stream up to 0x10, then branch to 0x100.
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0);
        chk("pre_branch_pc", {19'd0, pc_out}, 32'h10);
        step(1'b1, 13'h0100, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("branch_target", {19'd0, pc_out}, 32'h100);
        step(1'b0, '0, 1'b0);

        // Branch while the skid is holding: held instruction is discarded.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 13'h0200, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("held_branch_target", {19'd0, pc_out}, 32'h200);

        // Back-to-back branches: last one wins.
        step(1'b1, 13'h0300, 1'b0);
        step(1'b1, 13'h0400, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("last_branch_wins", {19'd0, pc_out}, 32'h400);

        // Address wrap.
        step(1'b1, 13'h1FFE, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        chk("wrap_pc", {19'd0, pc_out}, 32'h0000);

        // Random stall/branch traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 13'($urandom_range(0, 8191)),
                 ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
        end

        // Reset mid-operation while HELD.
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst_pc_out", {19'd0, pc_out}, 32'd0);
        chk("async_rst_imem_addr", {19'd0, imem_addr}, 32'd0);
        stall = 1'b0;
        @(posedge clk);
        #3;
        chk("rst_hold_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0);
        chk("reboot_pc3", {19'd0, pc_out}, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
